// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register-access slave.
package spi_reg_pkg;

    localparam logic [1:0] CMD_WR = 2'b10;
    localparam logic [1:0] CMD_RD = 2'b01;

    localparam int FRAME_LEN     = 15;
    localparam int ADDR_LAST_BIT = 5;
    localparam int PAD_BIT       = 6;

    // Bit positions of the pins inside the synchronizer vectors
    localparam int PIN_SCK  = 2;
    localparam int PIN_CSN  = 1;
    localparam int PIN_MOSI = 0;

    typedef enum logic [0:0] {
        ST_WAIT_CSN = 1'b0,
        ST_SHIFT    = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for SCK/CSN/MOSI plus a registered SCK-rise pulse.
// CSN and MOSI get one extra stage so they line up with the rise pulse.
module spi_pin_sync
    import spi_reg_pkg::*;
(
    input  logic clk,
    input  logic rst_slave,
    input  logic spi_clk,
    input  logic spi_csn,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic csn_s,
    output logic mosi_s
);

    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic [2:0] dly_q,  dly_d;
    logic       rise_q, rise_d;

    always_comb begin
        meta_d = {spi_clk, spi_csn, spi_mosi};
        sync_d = meta_q;
        dly_d  = sync_q;
        rise_d = sync_q[PIN_SCK] & ~dly_q[PIN_SCK];
    end

    always_ff @(posedge clk or posedge rst_slave) begin
        if (rst_slave) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
        end
    end

    assign sck_rise = rise_q;
    assign csn_s    = dly_q[PIN_CSN];
    assign mosi_s   = dly_q[PIN_MOSI];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI (mode 0) to parallel register-bus bridge; every pin is oversampled in clk.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_WAIT_CSN | after reset or a completed frame: ignore SCK until CSN high
//   ST_SHIFT    | armed; SCK rises shift MOSI in while CSN is low
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int DW  = 8,
    parameter int AW  = 6,
    parameter int CNT = 6
)
(
    input  logic          clk,
    input  logic          rst_slave,
    input  logic [DW-1:0] rdata,
    input  logic          rvalid,
    output logic          ren,
    output logic [DW-1:0] wdata,
    output logic          wen,
    output logic [AW-3:0] addr,
    input  logic          spi_clk,
    input  logic          spi_csn,
    input  logic          spi_mosi,
    output logic          spi_miso
);

    localparam int FL = AW + 1 + DW;
    localparam logic [CNT-1:0] C_ADDR_LAST = CNT'(ADDR_LAST_BIT);
    localparam logic [CNT-1:0] C_PAD       = CNT'(PAD_BIT);
    localparam logic [CNT-1:0] C_LAST      = CNT'(FRAME_LEN - 1);

    logic sck_rise;
    logic csn_s;
    logic mosi_s;

    spi_pin_sync u_pin_sync (
        .clk       (clk),
        .rst_slave (rst_slave),
        .spi_clk   (spi_clk),
        .spi_csn   (spi_csn),
        .spi_mosi  (spi_mosi),
        .sck_rise  (sck_rise),
        .csn_s     (csn_s),
        .mosi_s    (mosi_s)
    );

    spi_state_e    st_q,    st_d;
    logic [CNT-1:0] cnt_q,  cnt_d;
    logic [FL-2:0] rx_q,    rx_d;
    logic [FL-2:0] rx_sh;
    logic [DW-1:0] tx_q,    tx_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-3:0] addr_q,  addr_d;
    logic          ren_q,   ren_d;
    logic          wen_q,   wen_d;
    logic          miso_q,  miso_d;

    // rx holds one bit less than a frame: the final bit is taken from rx_sh
    always_comb begin
        rx_sh   = {rx_q[FL-3:0], mosi_s};
        st_d    = st_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        miso_d  = miso_q;

        if (csn_s) begin
            st_d   = ST_SHIFT;
            cnt_d  = '0;
            rx_d   = '0;
            tx_d   = '0;
            miso_d = 1'b0;
        end else begin
            if (rvalid) begin
                tx_d = rdata;
            end
            if (sck_rise && st_q == ST_SHIFT) begin
                rx_d  = rx_sh;
                cnt_d = cnt_q + CNT'(1);

                if (cnt_q == C_ADDR_LAST) begin
                    addr_d = rx_sh[AW-3:0];
                    ren_d  = (rx_sh[AW-1 -: 2] == CMD_RD);
                end

                if (cnt_q >= C_PAD && cnt_q < C_LAST) begin
                    miso_d = tx_q[DW-1];
                    tx_d   = {tx_q[DW-2:0], 1'b0};
                end

                // Frame complete: extra rises are dropped until CSN deasserts
                if (cnt_q == C_LAST) begin
                    st_d   = ST_WAIT_CSN;
                    cnt_d  = '0;
                    tx_d   = '0;
                    miso_d = 1'b0;
                    if (rx_q[FL-2 -: 2] == CMD_WR) begin
                        wdata_d = rx_sh[DW-1:0];
                        wen_d   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_slave) begin
        if (rst_slave) begin
            st_q    <= ST_WAIT_CSN;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            miso_q  <= miso_d;
        end
    end

    assign ren      = ren_q;
    assign wen      = wen_q;
    assign wdata    = wdata_q;
    assign addr     = addr_q;
    assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench: a host task drives SPI frames, a register-file responder
// answers ren, and a monitor checks strobes and captured MISO against a model.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int CNT = 6;
    localparam int FL = 15;

    logic          clk = 1'b0;
    logic          rst_slave = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rvalid = 1'b0;
    logic          ren;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [AW-3:0] addr;
    logic          spi_clk = 1'b0;
    logic          spi_csn = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;

    int checks = 0;
    int failures = 0;

    logic [3:0]  exp_rd_q[$];
    logic [11:0] exp_wr_q[$];
    logic [14:0] exp_miso_q[$];
    logic [14:0] obs_miso_q[$];

    logic [7:0] ref_mem[16];
    logic [7:0] env_mem[16];

    logic final_req = 1'b0;
    logic final_ack = 1'b0;

    logic [3:0]  ea;
    logic [11:0] ew;
    logic [14:0] em;
    logic [14:0] om;

    always #5 clk = ~clk;

    spi_reg_slave #(.DW(DW), .AW(AW), .CNT(CNT)) dut (
        .clk       (clk),
        .rst_slave (rst_slave),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .ren       (ren),
        .wdata     (wdata),
        .wen       (wen),
        .addr      (addr),
        .spi_clk   (spi_clk),
        .spi_csn   (spi_csn),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    // Register file: answers a read one clk after ren, stores writes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            if (!rst_slave) begin
                if (ren) begin
                    rdata  = env_mem[addr];
                    rvalid = 1'b1;
                end
                if (wen) env_mem[addr] = wdata;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_slave) begin
            checks++;
            if (ren !== 1'b0 || wen !== 1'b0 || spi_miso !== 1'b0 || addr !== 4'h0 || wdata !== 8'h00) begin
                failures++;
                $display("FAIL reset_outputs got ren=%b wen=%b miso=%b addr=%h wdata=%h required all 0",
                         ren, wen, spi_miso, addr, wdata);
            end
        end else begin
            if (ren && wen) begin
                failures++;
                $display("FAIL strobe_overlap got ren=1 wen=1 required never both");
            end
            if (ren) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL ren_unexpected got ren addr=%h required no ren", addr);
                end else begin
                    ea = exp_rd_q.pop_front();
                    if (addr !== ea) begin
                        failures++;
                        $display("FAIL ren_addr got %h required %h", addr, ea);
                    end
                end
            end
            if (wen) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL wen_unexpected got wen addr=%h wdata=%h required no wen", addr, wdata);
                end else begin
                    ew = exp_wr_q.pop_front();
                    if ({addr, wdata} !== ew) begin
                        failures++;
                        $display("FAIL wen_addr_data got addr=%h wdata=%h required addr=%h wdata=%h",
                                 addr, wdata, ew[11:8], ew[7:0]);
                    end
                end
            end
        end
        if (obs_miso_q.size() != 0) begin
            om = obs_miso_q.pop_front();
            checks++;
            if (exp_miso_q.size() == 0) begin
                failures++;
                $display("FAIL miso_unexpected got %h required no frame", om);
            end else begin
                em = exp_miso_q.pop_front();
                if (om !== em) begin
                    failures++;
                    $display("FAIL miso_frame got %h required %h", om, em);
                end
            end
        end
        if (final_req && !final_ack) begin
            checks++;
            if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || exp_miso_q.size() != 0) begin
                failures++;
                $display("FAIL pending_expect got rd=%0d wr=%0d miso=%0d outstanding required 0",
                         exp_rd_q.size(), exp_wr_q.size(), exp_miso_q.size());
            end
            final_ack = 1'b1;
        end
    end

    // Host side of one SPI frame; rst_after >= 0 pulses rst_slave after that bit's rise.
    task automatic spi_frame(input logic [14:0] f, input int nbits, input int rst_after);
        logic [14:0] cap;
        cap = '0;
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = f[14-i];
            repeat (4) @(negedge clk);
            cap[14-i] = spi_miso;
            spi_clk = 1'b1;
            if (i == rst_after) begin
                repeat (6) @(posedge clk);
                #1 rst_slave = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst_slave = 1'b0;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_clk = 1'b0;
        end
        repeat (4) @(negedge clk);
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        repeat (8) @(negedge clk);
        if (nbits == FL && rst_after < 0) obs_miso_q.push_back(cap);
    endtask

    // Reference model: expectations follow from the frame's command alone.
    task automatic do_frame(input logic [1:0] cmd, input logic [3:0] a, input logic pad,
                            input logic [7:0] d, input int nbits, input int rst_after);
        logic [14:0] f;
        f = {cmd, a, pad, d};
        if (nbits >= 6 && (rst_after < 0 || rst_after >= 5) && cmd == 2'b01)
            exp_rd_q.push_back(a);
        if (nbits == FL && rst_after < 0) begin
            if (cmd == 2'b10) begin
                exp_wr_q.push_back({a, d});
                ref_mem[a] = d;
            end
            exp_miso_q.push_back(cmd == 2'b01 ? {7'b0, ref_mem[a]} : 15'b0);
        end
        spi_frame(f, nbits, rst_after);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'h00;
            env_mem[i] = 8'h00;
        end
        #2 rst_slave = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_slave = 1'b0;
        repeat (8) @(negedge clk);

        do_frame(2'b10, 4'h0, 1'b0, 8'hA5, FL, -1);
        do_frame(2'b01, 4'h0, 1'b0, 8'h00, FL, -1);

        do_frame(2'b10, 4'h3, 1'b0, 8'h3C, FL, -1);
        do_frame(2'b10, 4'hF, 1'b0, 8'hC3, FL, -1);
        do_frame(2'b01, 4'h3, 1'b0, 8'h00, FL, -1);
        do_frame(2'b01, 4'hF, 1'b0, 8'h00, FL, -1);

        do_frame(2'b11, 4'h3, 1'b1, 8'hFF, FL, -1);
        do_frame(2'b00, 4'hF, 1'b1, 8'hFF, FL, -1);

        do_frame(2'b10, 4'h1, 1'b0, 8'hFF, 10, -1);
        do_frame(2'b10, 4'h1, 1'b0, 8'h5A, FL, -1);
        do_frame(2'b01, 4'h1, 1'b0, 8'h00, FL, -1);

        do_frame(2'b01, 4'h3, 1'b0, 8'h00, FL, 8);
        do_frame(2'b10, 4'h2, 1'b0, 8'h77, FL, -1);
        do_frame(2'b01, 4'h2, 1'b0, 8'h00, FL, -1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] c;
            logic [3:0] a;
            logic [7:0] d;
            logic       p;
            int         nb;
            c  = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            p  = 1'($urandom_range(0, 1));
            nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 14)) : FL;
            do_frame(c, a, p, d, nb, -1);
        end

        repeat (20) @(negedge clk);
        final_req = 1'b1;
        for (int k = 0; k < 10 && !final_ack; k++) @(negedge clk);
        if (!final_ack) begin
            $display("FAIL final_handshake got no ack required ack within 10 clk");
            $fatal(1, "monitor did not respond");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
